// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg
//   Shared types and constants for the latch bank controller and its
//   round-robin arbiter.
//   - state_t     : controller phase (IDLE / SETUP / OPEN / HOLD)
//   - DEF_*_CYC   : default phase lengths in clock cycles
//   - cnt_width() : width of the phase down-counter for a given set of
//                   phase lengths
//   - idx_width() : width of a requester index for a given requester count
package latch_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_OPEN_CYC  = 2;
    localparam int DEF_HOLD_CYC  = 1;

    // One spare bit above $clog2 of the longest phase, so that every
    // reload value (length-1) fits with room to spare.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. Searches upward from i_ptr,
//   wrapping modulo NREQ, for the first request not blocked by i_mask.
// Ports:
//   i_req  [NREQ] request vector
//   i_ptr  [PW]   index where the search starts
//   i_mask [NREQ] requests to ignore (1 = excluded)
//   o_gnt  [NREQ] one-hot grant (all zero when nothing is eligible)
//   o_idx  [PW]   index of the granted requester
//   o_vld         a grant was found
module rr_arbiter
    import latch_bank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    input  logic [NREQ-1:0] i_mask,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx,
    output logic            o_vld
);

    logic [NREQ-1:0] w_req_m;
    int              w_j;

    always_comb begin
        w_req_m = i_req & ~i_mask;
        o_gnt   = '0;
        o_idx   = '0;
        o_vld   = 1'b0;
        w_j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = (int'(i_ptr) + i) % NREQ;
            if (!o_vld && w_req_m[PW'(w_j)]) begin
                o_vld             = 1'b1;
                o_gnt[PW'(w_j)]   = 1'b1;
                o_idx             = PW'(w_j);
            end
        end
    end

endmodule

// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl
//   Arbitrates NREQ requesters onto a bank of 2**AW transparent latch words.
//   Each transaction runs a timed SETUP -> OPEN -> HOLD window on the chosen
//   word and then pulses ack to the winner. The bank's enables are active
//   low: a latch is transparent while its enable is 0.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   req       [NREQ]     level request per requester
//   addr      [NREQ*AW]  word address, requester i at [i*AW +: AW]
//   wdata     [NREQ*DW]  write data, requester i at [i*DW +: DW]
//   ack       [NREQ]     one-cycle one-hot completion pulse
//   busy                 high whenever the controller is not IDLE
//   lat_data  [DW]       data bus to the bank
//   lat_en_n  [2**AW]    per-word enable, 0 = open
// Build option:
//   LATCH_BANK_CTRL_B2B_EN - on the last HOLD cycle arbitrate again with the
//   current winner masked and, on a hit, go straight to SETUP (no IDLE gap).
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and captures on a hit
// SETUP | data driven, all enables closed
// OPEN  | enable of the captured word low
// HOLD  | enables closed, data held; ack on the final cycle
module latch_bank_ctrl
    import latch_bank_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int AW        = 2,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int OPEN_CYC  = DEF_OPEN_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic [DW-1:0]        lat_data,
    output logic [(2**AW)-1:0]   lat_en_n
);

    localparam int NW = 2**AW;
    localparam int PW = idx_width(NREQ);
    localparam int CW = cnt_width(SETUP_CYC, OPEN_CYC, HOLD_CYC);

    localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] C_OPEN  = CW'(OPEN_CYC - 1);
    localparam logic [CW-1:0] C_HOLD  = CW'(HOLD_CYC - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_win;
    logic [NREQ-1:0] r_win_oh;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [NW-1:0]   r_en_n;
    logic [NREQ-1:0] r_ack;
    logic            r_busy;

    state_t          w_state_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic [PW-1:0]   w_ptr_nx;
    logic            w_capture;
    logic            w_last;

    logic [PW-1:0]   w_win_inc;
    logic [PW-1:0]   w_arb_ptr;
    logic [NREQ-1:0] w_arb_mask;
    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_gnt_idx;
    logic            w_gnt_vld;

    assign w_win_inc = (r_win == PW'(NREQ - 1)) ? '0 : r_win + PW'(1);

    // In HOLD the arbiter is looking at the next transaction: start from
    // where the pointer is about to land and exclude the current winner.
    // Only the back-to-back build acts on that result.
    assign w_arb_ptr  = (r_state == HOLD) ? w_win_inc : r_ptr;
    assign w_arb_mask = (r_state == HOLD) ? r_win_oh  : '0;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_req  (req),
        .i_ptr  (w_arb_ptr),
        .i_mask (w_arb_mask),
        .o_gnt  (w_gnt),
        .o_idx  (w_gnt_idx),
        .o_vld  (w_gnt_vld)
    );

    assign w_last = (r_cnt == '0);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ptr_nx   = r_ptr;
        w_capture  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_capture  = 1'b1;
                    w_state_nx = SETUP;
                    w_cnt_nx   = C_SETUP;
                end
            end
            SETUP: begin
                if (w_last) begin
                    w_state_nx = OPEN;
                    w_cnt_nx   = C_OPEN;
                end else begin
                    w_cnt_nx   = r_cnt - CW'(1);
                end
            end
            OPEN: begin
                if (w_last) begin
                    w_state_nx = HOLD;
                    w_cnt_nx   = C_HOLD;
                end else begin
                    w_cnt_nx   = r_cnt - CW'(1);
                end
            end
            HOLD: begin
                if (w_last) begin
                    w_ptr_nx = w_win_inc;
`ifdef LATCH_BANK_CTRL_B2B_EN
                    if (w_gnt_vld) begin
                        w_capture  = 1'b1;
                        w_state_nx = SETUP;
                        w_cnt_nx   = C_SETUP;
                    end else begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end
`else
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
`endif
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Outputs are registered from the next-state decode so each one changes
    // on exactly the edge that enters the phase it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_win    <= '0;
            r_win_oh <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_en_n   <= '1;
            r_ack    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nx;
            r_ptr  <= w_ptr_nx;
            r_busy <= (w_state_nx != IDLE);
            r_en_n <= (w_state_nx == OPEN) ? ~(NW'(1) << r_addr) : '1;
            r_ack  <= (w_state_nx == HOLD && w_cnt_nx == '0) ? r_win_oh : '0;
            if (w_capture) begin
                r_win    <= w_gnt_idx;
                r_win_oh <= w_gnt;
                r_addr   <= addr[int'(w_gnt_idx)*AW +: AW];
                r_data   <= wdata[int'(w_gnt_idx)*DW +: DW];
            end
        end
    end

    assign ack      = r_ack;
    assign busy     = r_busy;
    assign lat_data = r_data;
    assign lat_en_n = r_en_n;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
`timescale 1ns/1ps
module tb_latch_bank_ctrl;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 2;
    localparam int NW   = 4;

    // instance 0: default timing, instance 1: 3/1/2 timing
    localparam int S_A = 1, O_A = 2, H_A = 1;
    localparam int S_B = 3, O_B = 1, H_B = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NREQ-1:0]          t_req   [2];
    logic [NREQ-1:0][AW-1:0]  t_addr  [2];
    logic [NREQ-1:0][DW-1:0]  t_wdata [2];
    logic [NREQ-1:0]          o_ack   [2];
    logic                     o_busy  [2];
    logic [DW-1:0]            o_data  [2];
    logic [NW-1:0]            o_en    [2];

    int m_ptr  [2];
    int m_prev [2];
    int n_cmp = 0;
    int n_mis = 0;

    latch_bank_ctrl #(
        .NREQ(NREQ), .DW(DW), .AW(AW),
        .SETUP_CYC(S_A), .OPEN_CYC(O_A), .HOLD_CYC(H_A)
    ) u_dut_a (
        .clk(clk), .rst(rst), .req(t_req[0]), .addr(t_addr[0]), .wdata(t_wdata[0]),
        .ack(o_ack[0]), .busy(o_busy[0]), .lat_data(o_data[0]), .lat_en_n(o_en[0])
    );

    latch_bank_ctrl #(
        .NREQ(NREQ), .DW(DW), .AW(AW),
        .SETUP_CYC(S_B), .OPEN_CYC(O_B), .HOLD_CYC(H_B)
    ) u_dut_b (
        .clk(clk), .rst(rst), .req(t_req[1]), .addr(t_addr[1]), .wdata(t_wdata[1]),
        .ack(o_ack[1]), .busy(o_busy[1]), .lat_data(o_data[1]), .lat_en_n(o_en[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Round-robin choice: first set request at or above p, wrapping.
    function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic int len_setup(input int s); return (s == 0) ? S_A : S_B; endfunction
    function automatic int len_open (input int s); return (s == 0) ? O_A : O_B; endfunction
    function automatic int len_hold (input int s); return (s == 0) ? H_A : H_B; endfunction

    // Called at a negedge; the following posedge is the capture edge.
    task automatic do_txn(input int s, input int prev, input logic [DW-1:0] mid,
                          input bit add_rand, output int win, output bit chained);
        logic [NREQ-1:0] mr;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ed;
        logic [NW-1:0]   exp_en;
        logic [NREQ-1:0] exp_ack;
        int S, O, T;
        S = len_setup(s);
        O = len_open(s);
        T = S + O + len_hold(s);
        chained = 1'b0;
        mr = t_req[s];
        if (prev >= 0) mr[prev] = 1'b0;
        win = rr_pick(m_ptr[s], mr);
        if (win < 0) return;
        ea = t_addr[s][win];
        ed = t_wdata[s][win];
        for (int k = 0; k < T; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) begin
                if (prev >= 0) t_req[s][prev] = 1'b0;
                if (add_rand) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (!t_req[s][i] && i != prev && $urandom_range(1) == 1) begin
                            t_req[s][i]   = 1'b1;
                            t_addr[s][i]  = AW'($urandom);
                            t_wdata[s][i] = DW'($urandom);
                        end
                    end
                end
            end
            exp_en  = (k >= S && k < S + O) ? ~(NW'(1) << ea) : '1;
            exp_ack = (k == T - 1) ? (NREQ'(1) << win) : '0;
            chk("lat_data", 32'(o_data[s]), 32'(ed));
            chk("lat_en_n", 32'(o_en[s]), 32'(exp_en));
            chk("ack", 32'(o_ack[s]), 32'(exp_ack));
            chk("busy", 32'(o_busy[s]), 32'd1);
            if (k == S) begin
                t_wdata[s][win] = mid;
                t_addr[s][win]  = AW'($urandom);
            end
        end
        m_ptr[s] = (win + 1) % NREQ;
`ifdef LATCH_BANK_CTRL_B2B_EN
        mr = t_req[s];
        mr[win] = 1'b0;
        chained = (mr != '0);
`endif
        if (!chained) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_busy", 32'(o_busy[s]), 32'd0);
            chk("idle_ack", 32'(o_ack[s]), 32'd0);
            chk("idle_en", 32'(o_en[s]), 32'hF);
            chk("idle_data", 32'(o_data[s]), 32'(ed));
            t_req[s][win] = 1'b0;
        end
    endtask

    task automatic drain(input int s, input bit add_rand, input int max_txn);
        logic [NREQ-1:0] mr;
        int  w;
        bit  ch;
        for (int n = 0; n < max_txn; n++) begin
            mr = t_req[s];
            if (m_prev[s] >= 0) mr[m_prev[s]] = 1'b0;
            if (mr == '0) break;
            do_txn(s, m_prev[s], DW'($urandom), add_rand, w, ch);
            m_prev[s] = ch ? w : -1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr[0] = 0;  m_ptr[1] = 0;
        m_prev[0] = -1; m_prev[1] = -1;
    endtask

    task automatic load_rand(input int s);
        t_req[s] = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int i = 0; i < NREQ; i++) begin
            t_addr[s][i]  = AW'($urandom);
            t_wdata[s][i] = DW'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int  w;
        bit  ch;
        logic [NW-1:0] exp_en;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            t_req[s] = '0; t_addr[s] = '0; t_wdata[s] = '0;
            m_ptr[s] = 0;  m_prev[s] = -1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_en", 32'(o_en[s]), 32'hF);
            chk("rst_data", 32'(o_data[s]), 32'd0);
            chk("rst_ack", 32'(o_ack[s]), 32'd0);
            chk("rst_busy", 32'(o_busy[s]), 32'd0);
        end
        rst = 1'b0;

        // single write: requester 2 -> word 3, A5
        t_addr[0][2]  = 2'd3;
        t_wdata[0][2] = 8'hA5;
        t_req[0]      = 4'b0100;
        drain(0, 1'b0, 2);

        // contention from ptr=0 with all requests held
        pulse_reset();
        for (int i = 0; i < NREQ; i++) begin
            t_addr[0][i]  = AW'($urandom);
            t_wdata[0][i] = DW'($urandom);
        end
        t_req[0] = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_txn(0, m_prev[0], DW'($urandom), 1'b0, w, ch);
            m_prev[0] = ch ? w : -1;
            if (i < 4) t_req[0] = 4'b1111;
        end
        drain(0, 1'b0, 10);

        // captured data must survive a mid-OPEN change on the bus
        t_addr[0][0]  = AW'($urandom);
        t_wdata[0][0] = 8'h3C;
        t_req[0]      = 4'b0001;
        do_txn(0, -1, 8'h00, 1'b0, w, ch);
        m_prev[0] = ch ? w : -1;
        drain(0, 1'b0, 4);

        // reset in the middle of OPEN
        t_addr[0][0]  = 2'd1;
        t_wdata[0][0] = 8'h5A;
        t_req[0]      = 4'b0001;
        @(posedge clk);
        repeat (S_A) @(posedge clk);
        @(negedge clk);
        exp_en = ~(NW'(1) << 2'd1);
        chk("open_en", 32'(o_en[0]), 32'(exp_en));
        #2 rst = 1'b1;
        #1;
        chk("arst_en", 32'(o_en[0]), 32'hF);
        chk("arst_busy", 32'(o_busy[0]), 32'd0);
        chk("arst_ack", 32'(o_ack[0]), 32'd0);
        t_req[0] = 4'b0010;
        t_addr[0][1]  = 2'd2;
        t_wdata[0][1] = 8'hC3;
        @(negedge clk);
        rst = 1'b0;
        m_ptr[0] = 0;  m_ptr[1] = 0;
        m_prev[0] = -1; m_prev[1] = -1;
        drain(0, 1'b0, 4);

        // randomized traffic on the default-timing instance
        for (int r = 0; r < 4; r++) begin
            load_rand(0);
            drain(0, 1'b1, 8);
            drain(0, 1'b0, 12);
        end

        // 3/1/2 timing instance
        t_addr[1][1]  = 2'd2;
        t_wdata[1][1] = 8'h77;
        t_req[1]      = 4'b0010;
        drain(1, 1'b0, 2);
        for (int r = 0; r < 2; r++) begin
            load_rand(1);
            drain(1, 1'b1, 6);
            drain(1, 1'b0, 12);
        end

`ifdef LATCH_BANK_CTRL_B2B_EN
        // back-to-back: two captures with no idle cycle between them
        pulse_reset();
        t_addr[0][0] = 2'd0; t_wdata[0][0] = 8'h11;
        t_addr[0][1] = 2'd1; t_wdata[0][1] = 8'h22;
        t_req[0] = 4'b0011;
        drain(0, 1'b0, 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/latch_bank_ctrl.md
Name: latch_bank_ctrl

Overview:
- Arbitrates NREQ requesters that share a bank of 2**AW transparent DW-bit latch words; each word is a row of latch_udp-style cells.
- Latch cell convention: transparent while its enable is 0, holding while it is 1; the bank's enables are therefore active-low (lat_en_n).
- Per transaction the block sequences a timed setup -> open -> hold window on the selected word, then acknowledges the requester.
- Sits between requester logic and the latch bank; it is the only driver of the bank's data and enable lines.

Parameters:
- NREQ, 4, number of requesters (>=2)
- DW, 8, latch word width
- AW, 2, word address width; bank holds 2**AW words
- SETUP_CYC, 1, data-stable cycles before enable opens (>=1)
- OPEN_CYC, 2, cycles enable is held open/low (>=1)
- HOLD_CYC, 1, data-stable cycles after enable closes (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request, level
- addr  in  NREQ*AW  packed word address; requester i occupies [i*AW +: AW]
- wdata  in  NREQ*DW  packed write data; requester i occupies [i*DW +: DW]
- ack  out  NREQ  one-cycle completion pulse, one-hot
- busy  out  1  high in any state other than IDLE
- lat_data  out  DW  data bus to the bank
- lat_en_n  out  2**AW  per-word enable, 0 = transparent/open

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high; while rst=1: state=IDLE, lat_en_n=all 1s, lat_data=0, ack=0, busy=0, rr pointer=0, cycle counter=0.
- FSM states: IDLE, SETUP, OPEN, HOLD.
- IDLE: if any req bit is set at the clock edge:
  - pick the winner round-robin, searching upward from ptr and wrapping modulo NREQ;
  - capture the winner's index, addr and wdata into registers;
  - lat_data <= captured wdata; go to SETUP.
- SETUP: stay SETUP_CYC cycles; lat_en_n remains all 1s.
- OPEN: stay OPEN_CYC cycles; lat_en_n[captured addr]=0 and all other bits 1.
- HOLD: stay HOLD_CYC cycles; lat_en_n=all 1s.
  - ack[winner]=1 during the last HOLD cycle only.
  - The next edge sets ptr=(winner+1) mod NREQ and goes to IDLE.
- lat_data holds the captured value from SETUP entry until the next capture. It never changes during SETUP, OPEN or HOLD.
- At most one lat_en_n bit is ever 0. Enable transitions occur only at the SETUP->OPEN and OPEN->HOLD edges.
- Latency with defaults: req sampled at edge E0 -> SETUP at E0 -> OPEN at E0+1 and E0+2 -> HOLD at E0+3 (ack visible E0+3 to E0+4) -> IDLE at E0+4. Earliest next capture is at E0+5.
- Requester handshake:
  - req, addr and wdata must stay stable until ack is seen; req is deasserted in the cycle after ack.
  - After capture, changes to addr or wdata are ignored.
  - Dropping req mid-transaction does not abort it; ack still pulses.
- Simultaneous requests: resolved by round-robin only, with no fixed priority.
- Pointer wrap: after requester NREQ-1 wins, ptr returns to 0.
- Phase counter: width $clog2(max cycle parameter)+1. It reloads on every state entry and counts down to 0.
- Reset mid-transaction (e.g. during OPEN): lat_en_n returns to all 1s immediately (asynchronously); no ack is issued; the interrupted word's contents are undefined.

Optional Feature:
- Macro: LATCH_BANK_CTRL_B2B_EN.
- Defined:
  - On the last HOLD cycle, arbitrate among req with the current winner masked out.
  - If a request is found, capture it and go directly to SETUP, skipping the IDLE cycle.
  - busy stays 1 and ptr updates as normal.
- Undefined: HOLD always returns to IDLE for at least one cycle, as described above.

Decomposition:
- Package latch_bank_pkg:
  - state enum typedef (IDLE, SETUP, OPEN, HOLD);
  - default timing constants;
  - function computing the counter width.
- One natural sub-module, rr_arbiter: inputs req, ptr and mask; outputs a one-hot grant and its index, purely combinational. It is reused for the B2B masked arbitration.

Test Plan:
- Single write: req[2]=1, addr=3, wdata=8'hA5 -> lat_data=A5 from SETUP; lat_en_n=4'b0111 for exactly 2 cycles; ack=4'b0100 for 1 cycle, 4 cycles after capture.
- Contention: req=4'b1111 held, ptr=0 -> grant order 0,1,2,3,0. Each ack is one-hot and lat_en_n never has two zeros.
- Data stability: change wdata[0] to 8'h00 mid-OPEN -> lat_data stays at the captured 8'h3C through HOLD.
- Reset during OPEN: rst=1 -> lat_en_n=4'b1111, busy=0, ack=0 at once; after release, req[1]=1 is granted first (ptr=0 and req[0]=0).
- Timing parameters: SETUP_CYC=3, OPEN_CYC=1, HOLD_CYC=2 -> counted phase lengths are 3/1/2 and ack falls in the 2nd HOLD cycle.
- With LATCH_BANK_CTRL_B2B_EN and req=4'b0011 -> the second capture happens on the ack edge, busy never drops, and the transaction period is 4 cycles instead of 5.
